// File: rtl/mole_scheduler_if.sv
// Control/status bundle between the game FSM, keypad controller and mole_scheduler.
interface mole_scheduler_if #(
  parameter int NUM_POS = 9,
  parameter int SCORE_W = 6,
  parameter int TIME_W  = 28
);
  logic               start;
  logic               abort;
  logic               load_seed;
  logic [7:0]         seed;
  logic [TIME_W-1:0]  time_on;
  logic [TIME_W-1:0]  time_between;
  logic [SCORE_W-1:0] max_hits;
  logic               use_lives;
  logic               key_valid;
  logic [3:0]         key;
  logic [NUM_POS-1:0] lights;
  logic [3:0]         light_pos;
  logic [SCORE_W-1:0] light_counter;
  logic [SCORE_W-1:0] total_points;
  logic [1:0]         lives_left;
  logic               busy;
  logic               done;

  modport master (
    output start, abort, load_seed, seed, time_on, time_between, max_hits,
           use_lives, key_valid, key,
    input  lights, light_pos, light_counter, total_points, lives_left, busy, done
  );

  modport slave (
    input  start, abort, load_seed, seed, time_on, time_between, max_hits,
           use_lives, key_valid, key,
    output lights, light_pos, light_counter, total_points, lives_left, busy, done
  );
endinterface

// File: rtl/mole_scheduler.sv
// Whack-a-mole sequencer: gap/on windows, LFSR position pick, key arbitration,
// score, flick count and lives bookkeeping.
module mole_scheduler #(
  parameter int NUM_POS = 9,
  parameter int SCORE_W = 6,
  parameter int TIME_W  = 28,
  parameter int LIVES   = 3
) (
  input  logic            CLOCK_50,
  input  logic            reset,
  mole_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_ON,
    S_HIT,
    S_DONE
  } state_e;

  localparam logic [7:0]         LFSR_INIT = 8'hA5;
  localparam logic [3:0]         NPOS      = 4'(NUM_POS);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);
  localparam logic [1:0]         LIVES_INIT = 2'(LIVES);

  state_e             state_q, state_d;
  logic [7:0]         lfsr_q, lfsr_d;
  logic [TIME_W-1:0]  timer_q, timer_d;
  logic [NUM_POS-1:0] lights_q, lights_d;
  logic [3:0]         light_pos_q, light_pos_d;
  logic [SCORE_W-1:0] light_counter_q, light_counter_d;
  logic [SCORE_W-1:0] total_points_q, total_points_d;
  logic [1:0]         lives_left_q, lives_left_d;
  logic               use_lives_q, use_lives_d;

  logic               lfsr_fb;
  logic [3:0]         cand_fold;
  logic [3:0]         cand;
  logic [SCORE_W-1:0] max_eff;
  logic               key_hit;

  always_comb begin
    lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    if (bus.load_seed) begin
      lfsr_d = (bus.seed == 8'h00) ? LFSR_INIT : bus.seed;
    end else begin
      lfsr_d = {lfsr_q[6:0], lfsr_fb};
    end
  end

  // Fold the 4-bit LFSR slice into range, then step past a repeat of the last mole.
  always_comb begin
    cand_fold = (lfsr_q[3:0] >= NPOS) ? (lfsr_q[3:0] - NPOS) : lfsr_q[3:0];
    cand      = cand_fold;
    if ((cand_fold == light_pos_q) && (light_counter_q != '0)) begin
      cand = (cand_fold == (NPOS - 4'd1)) ? 4'd0 : (cand_fold + 4'd1);
    end
  end

  assign max_eff = (bus.max_hits == '0) ? SCORE_ONE : bus.max_hits;
  assign key_hit = bus.key_valid && (bus.key == light_pos_q);

  always_comb begin
    state_d         = state_q;
    timer_d         = timer_q;
    lights_d        = lights_q;
    light_pos_d     = light_pos_q;
    light_counter_d = light_counter_q;
    total_points_d  = total_points_q;
    lives_left_d    = lives_left_q;
    use_lives_d     = use_lives_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        lights_d = '0;
        if (bus.start) begin
          light_counter_d = '0;
          total_points_d  = '0;
          lives_left_d    = LIVES_INIT;
          use_lives_d     = bus.use_lives;
          timer_d         = bus.time_between;
          state_d         = S_GAP;
        end
      end
      S_GAP: begin
        if (timer_q == '0) begin
          light_pos_d     = cand;
          lights_d        = '0;
          lights_d[cand]  = 1'b1;
          light_counter_d = light_counter_q + SCORE_ONE;
          timer_d         = bus.time_on;
          state_d         = S_ON;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_ON: begin
        timer_d = timer_q - 1'b1;
        // A hit on the final on-cycle wins over the timeout, so no life is lost.
        if (key_hit) begin
          if (total_points_q != SCORE_MAX) begin
            total_points_d = total_points_q + SCORE_ONE;
          end
          lights_d = '0;
          state_d  = S_HIT;
        end else if (timer_q == '0) begin
          lights_d = '0;
          if (use_lives_q && (lives_left_q != 2'd0)) begin
            lives_left_d = lives_left_q - 2'd1;
          end
          state_d = S_HIT;
        end
      end
      S_HIT: begin
        lights_d = '0;
        if (use_lives_q && (lives_left_q == 2'd0)) begin
          state_d = S_DONE;
        end else if (light_counter_q >= max_eff) begin
          state_d = S_DONE;
        end else begin
          timer_d = bus.time_between;
          state_d = S_GAP;
        end
      end
      default: begin
        lights_d = '0;
        state_d  = S_IDLE;
      end
    endcase

    if (bus.abort) begin
      state_d         = S_IDLE;
      lights_d        = '0;
      timer_d         = '0;
      light_counter_d = '0;
      total_points_d  = '0;
      lives_left_d    = LIVES_INIT;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      lfsr_q          <= LFSR_INIT;
      timer_q         <= '0;
      lights_q        <= '0;
      light_pos_q     <= '0;
      light_counter_q <= '0;
      total_points_q  <= '0;
      lives_left_q    <= LIVES_INIT;
      use_lives_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      lfsr_q          <= lfsr_d;
      timer_q         <= timer_d;
      lights_q        <= lights_d;
      light_pos_q     <= light_pos_d;
      light_counter_q <= light_counter_d;
      total_points_q  <= total_points_d;
      lives_left_q    <= lives_left_d;
      use_lives_q     <= use_lives_d;
    end
  end

  assign bus.lights        = lights_q;
  assign bus.light_pos     = light_pos_q;
  assign bus.light_counter = light_counter_q;
  assign bus.total_points  = total_points_q;
  assign bus.lives_left    = lives_left_q;
  assign bus.busy          = (state_q == S_GAP) || (state_q == S_ON) || (state_q == S_HIT);
  assign bus.done          = (state_q == S_DONE);

endmodule

// File: tb/tb_mole_scheduler.sv
// Self-checking bench for mole_scheduler: round-level reference model with
// randomized timing, seeds and key behaviour.
module tb_mole_scheduler;
  localparam int NP = 9;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [7:0] m_lfsr;

  mole_scheduler_if #(.NUM_POS(9), .SCORE_W(6), .TIME_W(28)) bus_if ();

  mole_scheduler #(
    .NUM_POS(9),
    .SCORE_W(6),
    .TIME_W (28),
    .LIVES  (3)
  ) dut (
    .CLOCK_50(clk),
    .reset   (rst),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  // Reference LFSR: x^8+x^6+x^5+x^4+1, seed 0 maps to A5.
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 8'hA5;
    else if (bus_if.load_seed) m_lfsr <= (bus_if.seed == 8'h00) ? 8'hA5 : bus_if.seed;
    else m_lfsr <= lfsr_step(m_lfsr);
  end

  function automatic int pick_pos(input logic [7:0] v, input int prev, input int k);
    int c;
    c = int'(v[3:0]) % NP;
    if (k > 1 && c == prev) c = (c + 1) % NP;
    return c;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs;
    bus_if.start        = 1'b0;
    bus_if.abort        = 1'b0;
    bus_if.load_seed    = 1'b0;
    bus_if.seed         = 8'h00;
    bus_if.time_on      = '0;
    bus_if.time_between = '0;
    bus_if.max_hits     = '0;
    bus_if.use_lives    = 1'b0;
    bus_if.key_valid    = 1'b0;
    bus_if.key          = 4'd0;
  endtask

  task automatic load_seed_val(input logic [7:0] s);
    bus_if.load_seed = 1'b1;
    bus_if.seed      = s;
    @(negedge clk);
    bus_if.load_seed = 1'b0;
  endtask

  // Plays one round from IDLE/DONE. hit_mode: 0 none, 1 all, 2 random.
  // hit_cyc: 0 random on-cycle, <0 last on-cycle, else that on-cycle.
  task automatic run_round(input int tb, input int ton, input int mh, input int lm,
                           input int hit_mode, input int hit_cyc, input int wrong,
                           input int glitch, input int abort_after);
    int tp = 0;
    int lives = 3;
    int prev = -1;
    int pos, h, limit;
    logic hit;
    logic [8:0] exp_l;
    limit = (mh == 0) ? 1 : mh;
    bus_if.time_between = 28'(tb);
    bus_if.time_on      = 28'(ton);
    bus_if.max_hits     = 6'(mh);
    bus_if.use_lives    = (lm != 0);
    bus_if.start        = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      for (int g = 1; g <= tb + 1; g++) begin
        checks++;
        if (bus_if.lights !== 9'd0 || bus_if.busy !== 1'b1 || bus_if.done !== 1'b0) begin
          failures++;
          $display("FAIL gap mole=%0d cyc=%0d lights=%b busy=%b done=%b want lights=0 busy=1 done=0",
                   k, g, bus_if.lights, bus_if.busy, bus_if.done);
        end
        if (g <= tb) @(negedge clk);
      end
      pos   = pick_pos(m_lfsr, prev, k);
      exp_l = 9'd1 << pos;
      @(negedge clk);
      if (k > 1) begin
        checks++;
        if (int'(bus_if.light_pos) == prev) begin
          failures++;
          $display("FAIL repeat mole=%0d light_pos=%0d equals previous=%0d", k, bus_if.light_pos, prev);
        end
      end
      hit = (hit_mode == 1) || (hit_mode == 2 && $urandom_range(0, 1) == 1);
      if (hit_cyc == 0) h = int'($urandom_range(1, ton + 1));
      else if (hit_cyc < 0 || hit_cyc > ton + 1) h = ton + 1;
      else h = hit_cyc;
      for (int c = 1; c <= ton + 1; c++) begin
        checks++;
        if (bus_if.lights !== exp_l || bus_if.light_pos !== 4'(pos) ||
            bus_if.light_counter !== 6'(k)) begin
          failures++;
          $display("FAIL on_window mole=%0d cyc=%0d lights=%b pos=%0d cnt=%0d want lights=%b pos=%0d cnt=%0d",
                   k, c, bus_if.lights, bus_if.light_pos, bus_if.light_counter, exp_l, pos, k);
        end
        if (k == glitch && c == 1) bus_if.start = 1'b1;
        if (hit && c == h) begin
          bus_if.key_valid = 1'b1;
          bus_if.key       = 4'(pos);
        end else if (wrong != 0 && $urandom_range(0, 2) == 0) begin
          bus_if.key_valid = 1'b1;
          if ($urandom_range(0, 3) == 0) bus_if.key = 4'($urandom_range(9, 15));
          else bus_if.key = 4'((pos + 1 + int'($urandom_range(0, 7))) % NP);
        end
        @(negedge clk);
        bus_if.start     = 1'b0;
        bus_if.key_valid = 1'b0;
        if (hit && c == h) break;
      end
      if (hit) tp = (tp < 63) ? tp + 1 : 63;
      else if (lm != 0) lives--;
      checks++;
      if (bus_if.lights !== 9'd0 || bus_if.busy !== 1'b1 || bus_if.done !== 1'b0 ||
          bus_if.total_points !== 6'(tp) || bus_if.lives_left !== 2'(lives)) begin
        failures++;
        $display("FAIL hit_state mole=%0d lights=%b busy=%b pts=%0d lives=%0d want lights=0 busy=1 pts=%0d lives=%0d",
                 k, bus_if.lights, bus_if.busy, bus_if.total_points, bus_if.lives_left, tp, lives);
      end
      prev = pos;
      @(negedge clk);
      if ((lm != 0 && lives == 0) || k >= limit) begin
        checks++;
        if (bus_if.done !== 1'b1 || bus_if.busy !== 1'b0 || bus_if.lights !== 9'd0 ||
            bus_if.light_counter !== 6'(k) || bus_if.total_points !== 6'(tp) ||
            bus_if.lives_left !== 2'(lives) || bus_if.light_pos !== 4'(pos)) begin
          failures++;
          $display("FAIL done_state done=%b busy=%b cnt=%0d pts=%0d lives=%0d pos=%0d want done=1 busy=0 cnt=%0d pts=%0d lives=%0d pos=%0d",
                   bus_if.done, bus_if.busy, bus_if.light_counter, bus_if.total_points,
                   bus_if.lives_left, bus_if.light_pos, k, tp, lives, pos);
        end
        return;
      end
      if (abort_after == k) begin
        bus_if.abort     = 1'b1;
        bus_if.start     = 1'b1;
        bus_if.key_valid = 1'b1;
        bus_if.key       = 4'(pos);
        @(negedge clk);
        bus_if.abort     = 1'b0;
        bus_if.start     = 1'b0;
        bus_if.key_valid = 1'b0;
        checks++;
        if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0 || bus_if.lights !== 9'd0 ||
            bus_if.light_counter !== 6'd0 || bus_if.total_points !== 6'd0 ||
            bus_if.lives_left !== 2'd3) begin
          failures++;
          $display("FAIL abort busy=%b done=%b lights=%b cnt=%0d pts=%0d lives=%0d want all idle/cleared lives=3",
                   bus_if.busy, bus_if.done, bus_if.lights, bus_if.light_counter,
                   bus_if.total_points, bus_if.lives_left);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
          failures++;
          $display("FAIL abort_idle busy=%b done=%b want busy=0 done=0", bus_if.busy, bus_if.done);
        end
        return;
      end
    end
  endtask

  task automatic test_reset;
    checks++;
    if (bus_if.lights !== 9'd0 || bus_if.light_pos !== 4'd0 || bus_if.light_counter !== 6'd0 ||
        bus_if.total_points !== 6'd0 || bus_if.lives_left !== 2'd3 ||
        bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
      failures++;
      $display("FAIL reset_init lights=%b pos=%0d cnt=%0d pts=%0d lives=%0d busy=%b done=%b want 0/0/0/0/3/0/0",
               bus_if.lights, bus_if.light_pos, bus_if.light_counter, bus_if.total_points,
               bus_if.lives_left, bus_if.busy, bus_if.done);
    end
    bus_if.time_between = 28'd0;
    bus_if.time_on      = 28'd5;
    bus_if.max_hits     = 6'd3;
    bus_if.start        = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_if.lights === 9'd0 || bus_if.light_counter !== 6'd1) begin
      failures++;
      $display("FAIL reset_pre_on lights=%b cnt=%0d want nonzero lights cnt=1",
               bus_if.lights, bus_if.light_counter);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus_if.lights !== 9'd0 || bus_if.light_pos !== 4'd0 || bus_if.light_counter !== 6'd0 ||
        bus_if.total_points !== 6'd0 || bus_if.lives_left !== 2'd3 ||
        bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_on lights=%b pos=%0d cnt=%0d pts=%0d lives=%0d busy=%b done=%b want 0/0/0/0/3/0/0",
               bus_if.lights, bus_if.light_pos, bus_if.light_counter, bus_if.total_points,
               bus_if.lives_left, bus_if.busy, bus_if.done);
    end
    @(negedge clk);
    rst = 1'b0;
    run_round(0, 1, 2, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_no_keys;
    load_seed_val(8'h01);
    run_round(2, 3, 2, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_hits;
    load_seed_val(8'h01);
    run_round(2, 3, 2, 0, 1, 2, 0, 0, 0);
  endtask

  task automatic test_last_cycle_hit;
    run_round(1, 3, 3, 1, 1, -1, 1, 0, 0);
  endtask

  task automatic test_lives;
    run_round(2, 2, 10, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_zero_max;
    run_round(1, 2, 0, 0, 2, 0, 1, 0, 0);
  endtask

  task automatic test_saturate;
    run_round(int'($urandom_range(0, 2)), int'($urandom_range(1, 3)), 63, 0, 1, 0, 1, 5, 0);
  endtask

  task automatic test_abort;
    run_round(4, 2, 10, 0, 1, 0, 0, 0, 2);
  endtask

  task automatic test_back_to_back;
    for (int r = 0; r < 6; r++) begin
      if ($urandom_range(0, 1) == 1)
        load_seed_val(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
      run_round(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 6)), int'($urandom_range(0, 1)),
                2, 0, 1, 0, 0);
    end
  endtask

  initial begin
    idle_inputs();
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_no_keys();
    test_hits();
    test_last_cycle_hit();
    test_lives();
    test_zero_max();
    test_saturate();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
